// File: rtl/gt_link_tx_arbiter.sv
// GT link transmit arbiter: round-robin with bounded bursts and starvation
// preemption over valid/ready requesters, registered 64-bit link output.
module gt_link_tx_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_REQ      = 3,
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [1:0]                    grant_idx,
  output logic                          grant_active,
  output logic                          starve_event
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [CNT_W-1:0] MAXB = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] LIM  = CNT_W'(STARVE_LIMIT);

  state_t                  state_q, state_d;
  logic [1:0]              owner_q, owner_d;
  logic [1:0]              rr_q, rr_d;
  logic [CNT_W-1:0]        burst_q, burst_d;
  logic [CNT_W-1:0]        wait_q [NUM_REQ];
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    out_valid_q;
  logic                    starve_q;

  logic [NUM_REQ-1:0]      starved;
  logic                    load_en;
  logic                    keep;
  logic                    xfer;
  logic                    starve_win;
  logic [1:0]              win;
  logic [1:0]              cand;

  assign load_en = ~out_valid_q | out_ready;

  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_REQ; i++)
      starved[i] = req_valid[i] && (wait_q[i] >= LIM);
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    burst_d    = burst_q;
    win        = owner_q;
    cand       = '0;
    keep       = 1'b0;
    xfer       = 1'b0;
    starve_win = 1'b0;
    if (load_en) begin
      keep = (state_q == HOLD) && req_valid[owner_q]
          && (burst_q < MAXB) && (starved == '0);
      if (keep) begin
        xfer    = 1'b1;
        burst_d = burst_q + CNT_W'(1);
      end else if (|starved) begin
        xfer       = 1'b1;
        starve_win = 1'b1;
        for (int i = NUM_REQ - 1; i >= 0; i--)
          if (starved[i]) win = 2'(i);
      end else if (|req_valid) begin
        xfer = 1'b1;
        // Descending scan so the first valid after rr_q is the last write;
        // the current owner sits last in this order.
        for (int k = NUM_REQ; k >= 1; k--) begin
          cand = 2'((int'(rr_q) + k) % NUM_REQ);
          if (req_valid[cand]) win = cand;
        end
      end else begin
        state_d = IDLE;
      end
      if (xfer && !keep) begin
        state_d = HOLD;
        owner_d = win;
        rr_d    = win;
        burst_d = CNT_W'(1);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && xfer)
      req_ready = NUM_REQ'(1) << win;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_q        <= 2'(NUM_REQ - 1);
      burst_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      starve_q    <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
        wait_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      burst_q  <= burst_d;
      starve_q <= starve_win;
      if (load_en) begin
        out_valid_q <= xfer;
        if (xfer)
          out_data_q <= req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!req_valid[i] || (xfer && (int'(win) == i)))
            wait_q[i] <= '0;
          else if (wait_q[i] < LIM)
            wait_q[i] <= wait_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign grant_idx    = owner_q;
  assign grant_active = (state_q == HOLD);
  assign starve_event = starve_q;

endmodule
